// File: rtl/buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// buzzer_sequencer
//
// Turns single-cycle Answer / TimeOver event pulses into timed level requests
// for the buzzer tone generator. TimeOver has priority: it aborts an answer
// tone in progress. An Answer that arrives while the TimeOver pattern is
// running is remembered (one level deep) and played once the pattern ends.
//
// Ports
//   CLK              in   1  system clock, rising edge
//   RST              in   1  asynchronous reset, active high
//   Evt_Answer       in   1  1-cycle pulse: a contestant answered
//   Evt_TimeOver     in   1  1-cycle pulse: answer timer expired
//   Mute             in   1  level: gates both tone requests low
//   Buzzer_Answer    out  1  level request for the answer tone
//   Buzzer_TimeOver  out  1  level request for the time-over tone
//   Busy             out  1  high when not idle or an answer is pending
//   Beep_Num         out  4  TimeOver beeps completed in current pattern
//
// Parameters
//   TICK_DIV  clock cycles per time tick (17-bit prescaler)
//   ANSWER_T  answer tone length, in ticks
//   TO_ON_T   TimeOver beep on-length, in ticks
//   TO_OFF_T  TimeOver inter-beep gap, in ticks
//   TO_BEEPS  number of TimeOver beeps per pattern (1..15)
// -----------------------------------------------------------------------------
module buzzer_sequencer #(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned ANSWER_T = 200,
   parameter int unsigned TO_ON_T  = 150,
   parameter int unsigned TO_OFF_T = 100,
   parameter int unsigned TO_BEEPS = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Evt_Answer,
   input  logic       Evt_TimeOver,
   input  logic       Mute,
   output logic       Buzzer_Answer,
   output logic       Buzzer_TimeOver,
   output logic       Busy,
   output logic [3:0] Beep_Num
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam int unsigned PreW  = 17;
   localparam int unsigned TickW = 16;

   localparam logic [PreW-1:0]  PreLast   = PreW'(TICK_DIV - 1);
   localparam logic [TickW-1:0] AnsLast   = TickW'(ANSWER_T - 1);
   localparam logic [TickW-1:0] ToOnLast  = TickW'(TO_ON_T - 1);
   localparam logic [TickW-1:0] ToOffLast = TickW'(TO_OFF_T - 1);
   localparam logic [3:0]       BeepTotal = 4'(TO_BEEPS);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StAnsOn = 2'd1;
   localparam logic [1:0] StToOn  = 2'd2;
   localparam logic [1:0] StToOff = 2'd3;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic [PreW-1:0]  pre_q, pre_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic             pend_q, pend_d;
   logic [3:0]       beep_q, beep_d;
   logic             ans_q, ans_d;
   logic             to_q, to_d;
   logic             busy_q, busy_d;

   // ---------------------------------------------------------------------------
   // Phase timer
   // ---------------------------------------------------------------------------
   logic             tick_end;
   logic [TickW-1:0] tick_limit;
   logic             phase_done;
   logic [3:0]       beep_inc;

   assign tick_end = (pre_q == PreLast);
   assign beep_inc = beep_q + 4'd1;

   // Length of the current state, in ticks, minus one.
   always_comb begin
      tick_limit = '0;
      unique case (state_q)
         StAnsOn: tick_limit = AnsLast;
         StToOn:  tick_limit = ToOnLast;
         StToOff: tick_limit = ToOffLast;
         default: tick_limit = '0;
      endcase
   end

   // True on the last clock cycle of a timed state.
   assign phase_done = (state_q != StIdle) && tick_end && (tick_q == tick_limit);

   // ---------------------------------------------------------------------------
   // Next-state, pending and beep count
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      beep_d  = beep_q;
      unique case (state_q)
         StIdle: begin
            if (Evt_TimeOver) begin
               state_d = StToOn;
               beep_d  = '0;
               // A simultaneous answer waits for the pattern to finish.
               if (Evt_Answer) begin
                  pend_d = 1'b1;
               end
            end else if (Evt_Answer || pend_q) begin
               state_d = StAnsOn;
               pend_d  = 1'b0;
            end
         end
         StAnsOn: begin
            // A second answer during the tone is dropped; TimeOver aborts it.
            if (Evt_TimeOver) begin
               state_d = StToOn;
               beep_d  = '0;
            end else if (phase_done) begin
               state_d = StIdle;
            end
         end
         StToOn: begin
            if (Evt_Answer) begin
               pend_d = 1'b1;
            end
            if (phase_done) begin
               beep_d = beep_inc;
               // Always return through IDLE so the tone module sees a gap
               // before a pending answer tone starts.
               if (beep_inc == BeepTotal) begin
                  state_d = StIdle;
               end else begin
                  state_d = StToOff;
               end
            end
         end
         StToOff: begin
            if (Evt_Answer) begin
               pend_d = 1'b1;
            end
            if (phase_done) begin
               state_d = StToOn;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Prescaler and tick counter: cleared on every state entry so each state
   // lasts exactly T * TICK_DIV cycles.
   // ---------------------------------------------------------------------------
   always_comb begin
      pre_d  = pre_q;
      tick_d = tick_q;
      if ((state_d != state_q) || (state_q == StIdle)) begin
         pre_d  = '0;
         tick_d = '0;
      end else if (tick_end) begin
         pre_d  = '0;
         tick_d = tick_q + TickW'(1);
      end else begin
         pre_d  = pre_q + PreW'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Registered outputs, decoded from the next state
   // ---------------------------------------------------------------------------
   always_comb begin
      ans_d  = (state_d == StAnsOn);
      to_d   = (state_d == StToOn);
      busy_d = (state_d != StIdle) || pend_d;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         pre_q   <= '0;
         tick_q  <= '0;
         pend_q  <= 1'b0;
         beep_q  <= '0;
         ans_q   <= 1'b0;
         to_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         pend_q  <= pend_d;
         beep_q  <= beep_d;
         ans_q   <= ans_d;
         to_q    <= to_d;
         busy_q  <= busy_d;
      end
   end

   // Mute only gates the requests; sequencing carries on underneath.
   assign Buzzer_Answer   = ans_q & ~Mute;
   assign Buzzer_TimeOver = to_q & ~Mute;
   assign Busy            = busy_q;
   assign Beep_Num        = beep_q;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_buzzer_sequencer
//
// Directed scenarios with hand-computed per-cycle expectations. The stimulus
// process queues the expected output vector for every cycle of a scenario;
// an independent monitor pops and compares on each falling clock edge.
// -----------------------------------------------------------------------------
module tb_buzzer_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       Evt_Answer = 1'b0;
   logic       Evt_TimeOver = 1'b0;
   logic       Mute = 1'b0;
   logic       Buzzer_Answer;
   logic       Buzzer_TimeOver;
   logic       Busy;
   logic [3:0] Beep_Num;

   buzzer_sequencer #(
      .TICK_DIV (4),
      .ANSWER_T (3),
      .TO_ON_T  (2),
      .TO_OFF_T (1),
      .TO_BEEPS (3)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .Evt_Answer      (Evt_Answer),
      .Evt_TimeOver    (Evt_TimeOver),
      .Mute            (Mute),
      .Buzzer_Answer   (Buzzer_Answer),
      .Buzzer_TimeOver (Buzzer_TimeOver),
      .Busy            (Busy),
      .Beep_Num        (Beep_Num)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int         at;
      int         test;
      int         rel;
      logic [6:0] exp;  // {answer, timeover, busy, beep_num}
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   localparam int LastRel = 62;

   function automatic logic in_rng(int r, int lo, int hi);
      return (r >= lo) && (r <= hi);
   endfunction

   // Expected outputs for scenario t at relative cycle r.
   function automatic logic [6:0] expv(int t, int r);
      logic       a, o, b;
      logic [3:0] n;
      a = 1'b0; o = 1'b0; b = 1'b0; n = 4'd0;
      case (t)
         1: begin
            a = in_rng(r, 11, 22);
            b = a;
         end
         2: begin
            o = in_rng(r, 11, 18) || in_rng(r, 23, 30) || in_rng(r, 35, 42);
            b = in_rng(r, 11, 42);
            n = (r >= 43) ? 4'd3 : (r >= 31) ? 4'd2 : (r >= 19) ? 4'd1 : 4'd0;
         end
         3: begin
            a = in_rng(r, 11, 15);
            o = in_rng(r, 16, 23) || in_rng(r, 28, 35) || in_rng(r, 40, 47);
            b = in_rng(r, 11, 47);
            n = (r >= 48) ? 4'd3 : (r >= 36) ? 4'd2 : (r >= 24) ? 4'd1 : 4'd0;
         end
         4, 6: begin
            o = in_rng(r, 11, 18) || in_rng(r, 23, 30) || in_rng(r, 35, 42);
            a = in_rng(r, 44, 55);
            b = in_rng(r, 11, 55);
            n = (r >= 43) ? 4'd3 : (r >= 31) ? 4'd2 : (r >= 19) ? 4'd1 : 4'd0;
            if (t == 6 && r >= 20) begin
               a = 1'b0; o = 1'b0; b = 1'b0; n = 4'd0;
            end
         end
         5: begin
            a = in_rng(r, 11, 22) && !in_rng(r, 12, 16);
            b = in_rng(r, 11, 22);
         end
         default: ;
      endcase
      return {a, o, b, n};
   endfunction

   // Monitor: compares queued expectations against the DUT on falling edges.
   initial begin
      logic [6:0] act;
      forever begin
         @(negedge CLK);
         act = {Buzzer_Answer, Buzzer_TimeOver, Busy, Beep_Num};
         while (sb.size() > 0 && sb[0].at <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (e.at != cyc) begin
               bad++;
               $display("FAIL missed_sample test%0d rel=%0d got cycle=%0d want cycle=%0d",
                        e.test, e.rel, cyc, e.at);
            end else if (act !== e.exp) begin
               bad++;
               $display("FAIL test%0d rel=%0d got ans=%b to=%b busy=%b beep=%0d want ans=%b to=%b busy=%b beep=%0d",
                        e.test, e.rel, act[6], act[5], act[4], act[3:0],
                        e.exp[6], e.exp[5], e.exp[4], e.exp[3:0]);
            end
         end
      end
   end

   task automatic run_test(input int t);
      int base;
      @(posedge CLK); #1;
      RST = 1'b1;
      Evt_Answer = 1'b0; Evt_TimeOver = 1'b0; Mute = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      base = cyc;
      for (int r = 0; r <= LastRel; r++) begin
         exp_t e;
         e.at = base + r; e.test = t; e.rel = r; e.exp = expv(t, r);
         sb.push_back(e);
      end
      for (int r = 0; r <= LastRel; r++) begin
         Evt_Answer   = (r == 10) && (t != 2);
         Evt_TimeOver = ((r == 10) && (t == 2 || t == 4 || t == 6)) || ((r == 15) && (t == 3));
         Mute         = (t == 5) && in_rng(r, 12, 16);
         RST          = (t == 6) && (r == 20);
         @(posedge CLK); #1;
      end
      Evt_Answer = 1'b0; Evt_TimeOver = 1'b0; Mute = 1'b0; RST = 1'b0;
   endtask

   initial begin
      int guard;
      for (int t = 1; t <= 6; t++) begin
         run_test(t);
      end
      guard = 0;
      while (sb.size() > 0 && guard < 20) begin
         @(posedge CLK);
         guard++;
      end
      if (sb.size() > 0) begin
         $display("FAIL drain got pending=%0d want pending=0", sb.size());
         bad++;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
